// File: rtl/usb_tx_pkt.sv
// Byte-serial USB-style packet transmitter: handshake or length-prefixed DATA packets
// with inline CRC-8, fed from a valid/ready payload stream.
module usb_tx_pkt #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned TMO_CYC  = 255,
    parameter logic [7:0]  CRC_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    input  logic [3:0]       btype,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [7:0]       pld_data,
    input  logic             pld_valid,
    output logic             pld_ready,
    output logic [7:0]       usb_txd,
    output logic             usb_txv,
    output logic             err
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    localparam logic [7:0] SYNC_B   = 8'h01;
    localparam logic [7:0] PID_ACK  = 8'h2D;
    localparam logic [7:0] PID_NAK  = 8'hA5;
    localparam logic [7:0] PID_STL  = 8'hE1;
    localparam logic [7:0] PID_DATA = 8'h3C;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_SYNC, S_PID, S_LENH, S_LENL, S_DATA, S_CRC, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        pid_q, pid_d;
    logic              is_data_q, is_data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  stall_q, stall_d;
    logic [7:0]        crc_q, crc_d;
    logic              err_q, err_d;
    logic [7:0]        txd_q, txd_d;
    logic              txv_q, txv_d;
    logic              fd_q, fd_d;
    logic              ready_q, ready_d;
    logic [15:0]       len16;
    logic [CNT_W-1:0]  cnt_inc;

    // CRC-8, polynomial 0x07, MSB-first over one byte
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign len16   = 16'(len_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pid_d     = pid_q;
        is_data_d = is_data_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        crc_d     = crc_q;
        err_d     = err_q;
        txd_d     = 8'h00;
        txv_d     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                err_d = 1'b0;
                if (fs) begin
                    len_d     = pkt_len;
                    is_data_d = 1'b0;
                    state_d   = S_SYNC;
                    case (btype)
                        4'd1: pid_d = PID_ACK;
                        4'd2: pid_d = PID_NAK;
                        4'd3: pid_d = PID_STL;
                        4'd4: begin
                            // Oversize DATA degrades to a STL handshake
                            if ({1'b0, pkt_len} > CNT_W'(MAX_LEN)) begin
                                pid_d = PID_STL;
                                err_d = 1'b1;
                            end else begin
                                pid_d     = PID_DATA;
                                is_data_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_SYNC: begin
                txd_d   = SYNC_B;
                txv_d   = 1'b1;
                crc_d   = CRC_INIT;
                cnt_d   = '0;
                stall_d = '0;
                state_d = S_PID;
            end
            S_PID: begin
                txd_d   = pid_q;
                txv_d   = 1'b1;
                state_d = is_data_q ? S_LENH : S_DONE;
            end
            S_LENH: begin
                txd_d   = len16[15:8];
                txv_d   = 1'b1;
                crc_d   = crc8_upd(crc_q, len16[15:8]);
                state_d = S_LENL;
            end
            S_LENL: begin
                txd_d   = len16[7:0];
                txv_d   = 1'b1;
                crc_d   = crc8_upd(crc_q, len16[7:0]);
                state_d = (len_q != '0) ? S_DATA : S_CRC;
            end
            S_DATA: begin
                if (pld_valid) begin
                    txd_d   = pld_data;
                    txv_d   = 1'b1;
                    crc_d   = crc8_upd(crc_q, pld_data);
                    cnt_d   = cnt_inc;
                    stall_d = '0;
                    if (cnt_inc == {1'b0, len_q}) begin
                        state_d = S_CRC;
                    end
                end else begin
                    stall_d = stall_q + TMO_W'(1);
                    // Stall timeout: abandon the packet without a CRC byte
                    if (stall_q == TMO_W'(TMO_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CRC: begin
                txd_d   = crc_q;
                txv_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!fs) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from next state so they track the state register exactly
        ready_d = (state_d == S_DATA);
        fd_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pid_q     <= 8'h00;
            is_data_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            stall_q   <= '0;
            crc_q     <= 8'h00;
            err_q     <= 1'b0;
            txd_q     <= 8'h00;
            txv_q     <= 1'b0;
            fd_q      <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            is_data_q <= is_data_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            crc_q     <= crc_d;
            err_q     <= err_d;
            txd_q     <= txd_d;
            txv_q     <= txv_d;
            fd_q      <= fd_d;
            ready_q   <= ready_d;
        end
    end

    assign fd        = fd_q;
    assign pld_ready = ready_q;
    assign usb_txd   = txd_q;
    assign usb_txv   = txv_q;
    assign err       = err_q;

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Directed bench for usb_tx_pkt: expected bytes are queued per packet and compared as
// the transmitter emits them.
module tb_usb_tx_pkt;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TMO_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fs;
    logic             fd;
    logic [3:0]       btype;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       pld_data;
    logic             pld_valid;
    logic             pld_ready;
    logic [7:0]       usb_txd;
    logic             usb_txv;
    logic             err;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb[$];
    logic [7:0] pl[0:31];
    bit         pkt_active = 1'b0;
    bit         first_seen = 1'b0;
    int         holes = 0;

    always #5 clk = ~clk;

    usb_tx_pkt #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .TMO_CYC (TMO_CYC),
        .CRC_INIT(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
        .fd       (fd),
        .btype    (btype),
        .pkt_len  (pkt_len),
        .pld_data (pld_data),
        .pld_valid(pld_valid),
        .pld_ready(pld_ready),
        .usb_txd  (usb_txd),
        .usb_txv  (usb_txv),
        .err      (err)
    );

    // Reference CRC-8 (x^8+x^2+x+1), bit-serial MSB-first
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte monitor: every valid output byte is popped against the scoreboard
    always @(posedge clk) begin
        logic [8:0] exp9;
        #1;
        if (rst && usb_txv) begin
            exp9 = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
            tests++;
            assert ({1'b0, usb_txd} === exp9) else begin
                fails++;
                $error("FAIL txbyte: observed %h expected %h (100 = no byte expected)",
                       {1'b0, usb_txd}, exp9);
            end
        end
        if (rst && pkt_active) begin
            if (usb_txv) first_seen = 1'b1;
            else if (first_seen && !fd) holes++;
        end
    end

    task automatic send(input logic [3:0] bt, input int len, input int gap_at, input int gap_n,
                        input int stop_after, input int rst_at, input logic exp_err,
                        input string tag);
        int         limit, idx, gapc, cyc;
        logic [7:0] c;
        logic [15:0] l16;
        bit         legal, over, abort, rdy_seen;
        legal = (bt >= 4'd1) && (bt <= 4'd4);
        over  = (bt == 4'd4) && (len > int'(MAX_LEN));
        abort = (bt == 4'd4) && !over && (stop_after >= 0) && (stop_after < len);
        limit = (stop_after >= 0) ? stop_after : len;
        l16   = 16'(len);
        if (legal) begin
            sb.push_back(8'h01);
            case (bt)
                4'd1: sb.push_back(8'h2D);
                4'd2: sb.push_back(8'hA5);
                4'd3: sb.push_back(8'hE1);
                default: sb.push_back(over ? 8'hE1 : 8'h3C);
            endcase
            if (bt == 4'd4 && !over) begin
                sb.push_back(l16[15:8]);
                sb.push_back(l16[7:0]);
                c = crc_step(crc_step(8'h00, l16[15:8]), l16[7:0]);
                for (int i = 0; i < limit; i++) begin
                    sb.push_back(pl[i]);
                    c = crc_step(c, pl[i]);
                end
                if (!abort) sb.push_back(c);
            end
        end
        holes = 0; first_seen = 1'b0; pkt_active = 1'b1;
        @(negedge clk);
        btype = bt; pkt_len = LEN_W'(len); fs = 1'b1;
        idx = 0; gapc = 0; cyc = 0; rdy_seen = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (fd) break;
            if (pld_ready) rdy_seen = 1'b1;
            if (rst_at >= 0 && idx == rst_at && pld_ready) begin
                #2 rst = 1'b0;
                #1 chk({tag, "_async_rst"}, {23'd0, fd, pld_ready, usb_txv, err, usb_txd}, 32'd0);
                pld_valid = 1'b0; fs = 1'b0; pkt_active = 1'b0;
                sb.delete();
                @(negedge clk) rst = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
            if (pld_ready && idx < limit) begin
                if (idx == gap_at && gapc < gap_n) begin
                    pld_valid = 1'b0;
                    gapc++;
                end else begin
                    pld_valid = 1'b1;
                    pld_data  = pl[idx];
                    idx++;
                end
            end else begin
                pld_valid = 1'b0;
            end
        end
        pkt_active = 1'b0;
        pld_valid  = 1'b0;
        chk({tag, "_fd"}, 32'(fd), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_bytes_left"}, 32'(sb.size()), 32'd0);
        chk({tag, "_ready_seen"}, 32'(rdy_seen), 32'((bt == 4'd4) && !over && (len > 0)));
        chk({tag, "_gaps"}, 32'(holes), 32'(abort ? int'(TMO_CYC) - 1 : gap_n));
        sb.delete();
        fs = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_fd_clear"}, 32'(fd), 32'd0);
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; btype = 4'd0; pkt_len = '0; pld_valid = 1'b0; pld_data = 8'h00;
        #2 rst = 1'b0;
        #1 chk("reset_outputs", {23'd0, fd, pld_ready, usb_txv, err, usb_txd}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send(4'd1, 0, -1, 0, -1, -1, 1'b0, "ack");
        send(4'd2, 0, -1, 0, -1, -1, 1'b0, "nak");
        send(4'd3, 0, -1, 0, -1, -1, 1'b0, "stl");
        pl[0] = 8'hA5;
        send(4'd4, 1, -1, 0, -1, -1, 1'b0, "data1");
        send(4'd4, 0, -1, 0, -1, -1, 1'b0, "data0");
        pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h0F;
        send(4'd4, 3, -1, 0, -1, -1, 1'b0, "data3");
        send(4'd4, 3, 1, 2, -1, -1, 1'b0, "data3_gap");
        send(4'd4, 2, -1, 0, 1, -1, 1'b1, "stall_abort");
        send(4'd4, int'(MAX_LEN) + 1, -1, 0, -1, -1, 1'b1, "oversize");
        send(4'd7, 0, -1, 0, -1, -1, 1'b1, "illegal");
        for (int i = 0; i < 32; i++) pl[i] = 8'($urandom_range(0, 255));
        send(4'd4, int'(MAX_LEN), -1, 0, -1, -1, 1'b0, "data_max");
        send(4'd4, 5, -1, 0, -1, 2, 1'b0, "mid_rst");
        send(4'd4, 2, -1, 0, -1, -1, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
